// File: rtl/next_piece_queue_if.sv
// Tile type shared with the next-region display, plus the next-pieces bus
// between the piece generator (master) and the spawn/render consumers (slave).
package GamePkg;
  typedef enum logic [2:0] {
    TILE_I = 3'd0, TILE_O = 3'd1, TILE_T = 3'd2, TILE_J = 3'd3,
    TILE_L = 3'd4, TILE_S = 3'd5, TILE_Z = 3'd6, BLANK  = 3'd7
  } tile_type_t;
  localparam int NEXT_PIECES_COUNT = 6;
endpackage

interface next_piece_queue_if #(parameter int N = GamePkg::NEXT_PIECES_COUNT);
  import GamePkg::*;
  localparam int CW = $clog2(N + 1);

  logic                 new_game;
  logic                 pop;
  logic                 pop_ack;
  tile_type_t [N-1:0]   pieces_queue;
  logic [CW-1:0]        queue_count;
  logic                 queue_full;
  logic [6:0]           bag_remaining;

  modport master (
    input  new_game, pop,
    output pop_ack, pieces_queue, queue_count, queue_full, bag_remaining
  );
  modport slave (
    output new_game, pop,
    input  pop_ack, pieces_queue, queue_count, queue_full, bag_remaining
  );
endinterface

// File: rtl/next_piece_queue.sv
// 7-bag tetromino generator feeding an ordered next-pieces queue (head = slot 0).
// A 16-bit LFSR proposes one candidate per cycle; rejected candidates simply retry.
module next_piece_queue
  import GamePkg::*;
#(
  parameter int          NEXT_PIECES_COUNT = 6,
  parameter logic [15:0] SEED              = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  next_piece_queue_if.master bus
);
  localparam int N  = NEXT_PIECES_COUNT;
  localparam int CW = $clog2(N + 1);
  localparam logic [15:0]   SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] FULL_CNT = CW'(N);

  logic [15:0]        r_lfsr;
  tile_type_t [N-1:0] r_queue;
  logic [CW-1:0]      r_count;
  logic               r_full;
  logic [6:0]         r_bag;

  logic [2:0]         w_cand;
  logic [7:0]         w_bag_ext;
  logic               w_pop_ack;
  logic               w_accept;
  logic [6:0]         w_bag_clr;
  logic [6:0]         w_bag_nxt;
  logic [CW-1:0]      w_wr_idx;
  logic [CW-1:0]      w_count_nxt;
  tile_type_t [N-1:0] w_queue_nxt;

  // Candidate 7 indexes the always-zero top bit, so it is rejected for free.
  assign w_cand    = r_lfsr[2:0];
  assign w_bag_ext = {1'b0, r_bag};
  assign w_pop_ack = bus.pop && (r_count != '0) && !bus.new_game && !rst;
  assign w_accept  = w_bag_ext[w_cand] && ((r_count < FULL_CNT) || w_pop_ack)
                     && !bus.new_game;

  always_comb begin
    w_bag_clr   = r_bag & ~(7'd1 << w_cand);
    w_bag_nxt   = r_bag;
    w_queue_nxt = r_queue;
    w_wr_idx    = r_count;
    w_count_nxt = r_count;
    if (w_accept)
      w_bag_nxt = (w_bag_clr == 7'd0) ? 7'h7F : w_bag_clr;
    if (w_pop_ack) begin
      for (int k = 0; k < N - 1; k++)
        w_queue_nxt[k] = r_queue[k+1];
      w_queue_nxt[N-1] = BLANK;
      w_wr_idx         = r_count - 1'b1;
    end
    // Append lands in the first empty slot as seen after this cycle's shift.
    if (w_accept) begin
      for (int k = 0; k < N; k++)
        if (CW'(k) == w_wr_idx)
          w_queue_nxt[k] = tile_type_t'(w_cand);
    end
    case ({w_accept, w_pop_ack})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // LFSR keeps running through new_game so a fresh game does not replay pieces.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED_EFF;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      for (int k = 0; k < N; k++)
        r_queue[k] <= BLANK;
      r_count <= '0;
      r_full  <= 1'b0;
      r_bag   <= 7'h7F;
    end else begin
      r_queue <= w_queue_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_bag   <= w_bag_nxt;
    end
  end

  assign bus.pop_ack       = w_pop_ack;
  assign bus.pieces_queue  = r_queue;
  assign bus.queue_count   = r_count;
  assign bus.queue_full    = r_full;
  assign bus.bag_remaining = r_bag;
endmodule

// File: tb/tb_next_piece_queue.sv
// Directed bench for next_piece_queue: hand-computed startup vectors from SEED
// 16'hACE1, then bag/ordering/new_game/reset sequences checked structurally.
module tb_next_piece_queue;
  import GamePkg::*;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  next_piece_queue_if #(.N(N)) bus ();

  next_piece_queue #(.NEXT_PIECES_COUNT(N), .SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pop;
    int         cnt;
    logic [6:0] bag;
    tile_type_t head;
    logic       full;
    logic       ack;
  } vec_t;

  vec_t       tbl [14];
  tile_type_t got [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_cnt"},  int'(bus.queue_count), 0);
    chk({nm, "_bag"},  int'(bus.bag_remaining), 'h7F);
    chk({nm, "_full"}, int'(bus.queue_full), 0);
    chk({nm, "_ack"},  int'(bus.pop_ack), 0);
    for (int k = 0; k < N; k++)
      chk({nm, "_blank"}, int'(bus.pieces_queue[k]), int'(BLANK));
  endtask

  initial begin
    tile_type_t old_q [N];
    logic       pend;
    logic       found;
    logic [6:0] mask;

    // State at the start of each cycle after reset release (candidates:
    // O,J,-,-,Z,L,O,T,L,I,O,T,S,...); pop held for the first two cycles.
    tbl[0]  = '{1'b1, 0, 7'h7F, BLANK,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1, 7'h7D, TILE_O, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1, 7'h75, TILE_J, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1, 7'h75, TILE_J, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1, 7'h75, TILE_J, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2, 7'h35, TILE_J, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3, 7'h25, TILE_J, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3, 7'h25, TILE_J, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4, 7'h21, TILE_J, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4, 7'h21, TILE_J, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5, 7'h20, TILE_J, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5, 7'h20, TILE_J, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 5, 7'h20, TILE_J, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 6, 7'h7F, TILE_J, 1'b1, 1'b0};

    bus.pop      = 1'b1;
    bus.new_game = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_state("rst_hold");

    // Startup vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst     = 1'b0;
      bus.pop = tbl[i].pop;
      #1;
      chk($sformatf("v%0d_cnt", i),  int'(bus.queue_count),     tbl[i].cnt);
      chk($sformatf("v%0d_bag", i),  int'(bus.bag_remaining),   int'(tbl[i].bag));
      chk($sformatf("v%0d_head", i), int'(bus.pieces_queue[0]), int'(tbl[i].head));
      chk($sformatf("v%0d_full", i), int'(bus.queue_full),      int'(tbl[i].full));
      chk($sformatf("v%0d_ack", i),  int'(bus.pop_ack),         int'(tbl[i].ack));
      if (bus.pop_ack) got.push_back(bus.pieces_queue[0]);
    end
    chk("full_s1", int'(bus.pieces_queue[1]), int'(TILE_Z));
    chk("full_s2", int'(bus.pieces_queue[2]), int'(TILE_L));
    chk("full_s3", int'(bus.pieces_queue[3]), int'(TILE_T));
    chk("full_s4", int'(bus.pieces_queue[4]), int'(TILE_I));
    chk("full_s5", int'(bus.pieces_queue[5]), int'(TILE_S));

    // Drain-on-full run: ordering after every pop, contiguity, 7-bag groups
    pend = 1'b0;
    for (int cyc = 0; cyc < 40000 && got.size() < 700; cyc++) begin
      @(negedge clk);
      bus.pop = bus.queue_full;
      #1;
      if (pend) begin
        for (int k = 0; k < N - 1; k++)
          chk("pop_shift", int'(bus.pieces_queue[k]), int'(old_q[k+1]));
        chk("pop_cnt_5or6", int'(bus.queue_count == 5 || bus.queue_count == 6), 1);
        chk("pop_tail", int'(bus.pieces_queue[N-1] == BLANK), int'(bus.queue_count == 5));
        pend = 1'b0;
      end
      chk("bag_nonzero", int'(bus.bag_remaining != 7'd0), 1);
      for (int k = 0; k < N; k++)
        chk("contig", int'(bus.pieces_queue[k] != BLANK), int'(k < int'(bus.queue_count)));
      if (bus.queue_full) chk("full_ack", int'(bus.pop_ack), 1);
      if (bus.pop_ack) begin
        got.push_back(bus.pieces_queue[0]);
        for (int k = 0; k < N; k++) old_q[k] = bus.pieces_queue[k];
        pend = 1'b1;
      end
    end
    chk("collect_700", got.size(), 700);
    for (int g = 0; g < got.size() / 7; g++) begin
      mask = 7'd0;
      for (int j = 0; j < 7; j++)
        if (got[g*7+j] != BLANK) mask[got[g*7+j]] = 1'b1;
      chk($sformatf("bag_perm_%0d", g), int'(mask), 'h7F);
    end

    // new_game while partially filled with pop requested
    @(negedge clk);
    bus.pop      = 1'b0;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      @(negedge clk); #1;
      if (bus.queue_count == 3) found = 1'b1;
    end
    chk("ng_reach3", int'(found), 1);
    bus.pop      = 1'b1;
    bus.new_game = 1'b1;
    #1;
    chk("ng_ack", int'(bus.pop_ack), 0);
    @(negedge clk);
    bus.pop      = 1'b0;
    bus.new_game = 1'b0;
    #1;
    chk_reset_state("ng");
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk); #1;
      if (bus.queue_count != 0) found = 1'b1;
    end
    chk("ng_refill", int'(found), 1);

    // Reset while full and popping
    found = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      @(negedge clk); #1;
      if (bus.queue_full) found = 1'b1;
    end
    chk("rst_reach_full", int'(found), 1);
    bus.pop = 1'b1;
    rst     = 1'b1;
    #1;
    chk("rst_ack_comb", int'(bus.pop_ack), 0);
    @(negedge clk); #1;
    chk_reset_state("rst_mid");
    rst     = 1'b0;
    bus.pop = 1'b0;
    @(negedge clk); #1;
    chk("rst_first_piece", int'(bus.pieces_queue[0]), int'(TILE_O));
    chk("rst_first_cnt", int'(bus.queue_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/next_piece_queue.md
Name: next_piece_queue

Overview:
- Producer side of the next-pieces interface. Generates tetromino types with a 7-bag randomizer and keeps an ordered queue of upcoming pieces.
- Drives the `pieces_queue` array that the next-region pixel driver renders.
- The spawn logic reads `pieces_queue[0]` and pulses `pop` to take it.
- Queue head is index 0. Each slot holds a GamePkg `tile_type_t`; unfilled slots read BLANK.

Parameters:
- NEXT_PIECES_COUNT, 6, queue depth; must match the GamePkg value used by the display.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- new_game  input  1  single-cycle pulse; flushes queue and bag, keeps LFSR state.
- pop  input  1  consumer takes the head piece this cycle.
- pop_ack  output  1  combinational; high when pop is accepted this cycle.
- pieces_queue  output  tile_type_t[NEXT_PIECES_COUNT]  registered queue contents, index 0 = next piece.
- queue_count  output  $clog2(NEXT_PIECES_COUNT+1)  number of filled slots.
- queue_full  output  1  queue_count == NEXT_PIECES_COUNT.
- bag_remaining  output  7  pieces still available in the current bag; bit order I,O,T,J,L,S,Z = bits 0..6.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - pieces_queue all BLANK; queue_count 0; queue_full 0; bag_remaining 7'h7F; LFSR = SEED.
  - pop_ack is 0 while rst is high.
- LFSR:
  - 16-bit Fibonacci, advances every cycle when not in reset, including during new_game.
  - Next state = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Candidate selection:
  - candidate = lfsr[2:0] (current value); values 0..6 map to I,O,T,J,L,S,Z; 7 is invalid.
- Accept condition: all of the following hold:
  - candidate valid;
  - bag_remaining[candidate] == 1;
  - slot available, i.e. queue_count < NEXT_PIECES_COUNT or pop_ack;
  - new_game == 0.
  - Otherwise no piece is generated this cycle. The retry is implicit, since the LFSR advances.
- On accept:
  - Clear bag_remaining[candidate].
  - If that leaves the bag 0, reload bag_remaining to 7'h7F in the same cycle; bag_remaining never reads 0.
  - Write the piece into the first empty slot, evaluated after any pop shift this cycle.
- pop_ack = pop && queue_count != 0 && !new_game && !rst.
  - pop with an empty queue is ignored: no shift, pop_ack 0.
- On pop_ack:
  - Slots shift toward index 0 (slot k ← slot k+1).
  - The vacated tail slot becomes BLANK unless filled by a same-cycle accept.
  - The consumer samples pieces_queue[0] in the cycle pop_ack is high.
- Simultaneous pop_ack and accept:
  - Shift and append in the same cycle; queue_count unchanged.
  - With a full queue, the new piece lands in slot NEXT_PIECES_COUNT-1.
- queue_count update: +1 on accept only; -1 on pop_ack only; unchanged on both or neither. It never exceeds NEXT_PIECES_COUNT or underflows.
- new_game:
  - Next cycle: all slots BLANK, queue_count 0, bag 7'h7F; LFSR not reset.
  - Overrides pop and accept in that cycle.
  - Refill restarts the following cycle.
- Priority: rst > new_game > (pop, accept).
- Invariants:
  - Occupied slots are contiguous from index 0; no BLANK precedes a non-BLANK.
  - Every aligned run of 7 generated pieces since reset or new_game is a permutation of {I,O,T,J,L,S,Z}.
- Latency:
  - A piece appears in pieces_queue the cycle after its accept.
  - The head is visible combinationally to the consumer; pop takes effect at the next edge.
- Implementation: no combinational path from pop to pieces_queue; all outputs except pop_ack are registered.

Test Plan:
- Reset fill: assert rst 3 cycles, release, pop=0 → queue_count rises by exactly 1 per accept cycle. queue_full within 200 cycles. Slots 0..5 non-BLANK and pairwise distinct. bag_remaining has exactly 1 bit set after 6 accepts.
- Bag property: pop every time queue_full, collect 700 pieces → each aligned group of 7 is a permutation of IOTJLSZ. bag_remaining resets to 7'h7F after every 7th accept.
- Pop ordering: full queue, record Q[0..5], pulse pop one cycle → pop_ack=1. Next cycle slots 0..4 equal old Q[1..5]. Slot 5 is either BLANK with count 5, or the newly accepted piece with count 6.
- Empty pop: immediately after reset, hold pop=1 during the first cycle (count 0) → pop_ack=0, count stays 0. Once count reaches 1, pop_ack=1 and the count stays ≤1 while pop is held.
- new_game mid-fill: pulse new_game when count=3 with pop=1 → next cycle all BLANK, count 0, bag 7'h7F, pop_ack=0. LFSR sequence continues, with no repeat of the post-reset value.
- Reset mid-operation: assert rst while full and popping → next cycle matches all reset values. The first piece after release equals the first piece produced after the original reset with the same SEED.
